// File: rtl/pattern_scan_ctrl.sv
// Per-word serial pattern scanner: accepts a word, shifts it MSB-first through a 4-bit window,
// counts (saturating) matches against a per-word pattern and reports the count.
module pattern_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       pat,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [3:0]        pat_q, pat_d;
  logic [2:0]        win_q, win_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q;
  logic              en;
  logic [3:0]        cand;

  // Outputs stay low while reset is low and for the cycle in which it is first sampled high.
  assign en   = RSTn & active_q;
  assign cand = {win_q, word_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    pat_d     = pat_q;
    win_d     = win_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    hit       = 1'b0;
    out_valid = 1'b0;
    out_count = '0;

    unique case (state_q)
      StIdle: begin
        in_ready = en;
        if (in_valid && en) begin
          word_d  = in_data;
          pat_d   = pat;
          win_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        bit_valid = en;
        bit_out   = en & word_q[WIDTH-1];
        hit       = en && (idx_q >= IdxW'(3)) && (cand == pat_q);
        win_d     = cand[2:0];
        word_d    = word_q << 1;
        idx_d     = idx_q + 1'b1;
        if (hit && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (idx_q == IdxW'(WIDTH - 1)) begin
          state_d = StReport;
        end
      end
      StReport: begin
        out_valid = en;
        out_count = en ? cnt_q : '0;
        if (out_ready && en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= StIdle;
      word_q   <= '0;
      pat_q    <= '0;
      win_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      pat_q    <= pat_d;
      win_q    <= win_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: default instance plus a CNT_W=2 instance for saturation.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       in_valid, out_ready;
  logic [7:0] in_data;
  logic [3:0] pat;
  logic       in_ready, bit_out, bit_valid, hit, out_valid;
  logic [3:0] out_count;

  logic       in_valid_b, out_ready_b;
  logic [7:0] in_data_b;
  logic [3:0] pat_b;
  logic       in_ready_b, bit_out_b, bit_valid_b, hit_b, out_valid_b;
  logic [1:0] out_count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut (
    .CLK       (clk),
    .RSTn      (RSTn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .pat       (pat),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .hit       (hit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  pattern_scan_ctrl #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
    .CLK       (clk),
    .RSTn      (RSTn),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .pat       (pat_b),
    .bit_out   (bit_out_b),
    .bit_valid (bit_valid_b),
    .hit       (hit_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_count (out_count_b)
  );

  // Drives one word from an IDLE negedge and records what the DUT shows per scan cycle.
  // Returns at the negedge of the first out_valid cycle (lat = cycles after the accept edge).
  task automatic scan(input logic [7:0] data, input logic [3:0] p, output logic rdy,
                      output logic [7:0] bits, output logic [7:0] hits, output logic [7:0] bv,
                      output int lat, output logic [3:0] cnt, output logic bv_rep);
    in_valid  = 1'b1;
    in_data   = data;
    pat       = p;
    out_ready = 1'b0;
    rdy       = in_ready;
    bits = '0; hits = '0; bv = '0; lat = 0; cnt = '0; bv_rep = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~data;
    pat      = ~p;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 8) begin
        bits[8-c] = bit_out;
        hits[8-c] = hit;
        bv[8-c]   = bit_valid;
      end
      if (out_valid) begin
        lat    = c;
        cnt    = out_count;
        bv_rep = bit_valid;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_report();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; in_valid = 1'b1; in_data = 8'h55; pat = 4'h5; out_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; pat_b = '0; out_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, bit_out, bit_valid, hit, out_valid, out_count} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0",
               {in_ready, bit_out, bit_valid, hit, out_valid, out_count});
    end
    n_cmp++;
    if (in_ready_b !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready_b: got %b want 0", in_ready_b);
    end
    in_valid = 1'b0;
    RSTn     = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_early: in_ready got %b want 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bit_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: rdy/ov/bv got %b%b%b want 100", in_ready, out_valid, bit_valid);
    end
  endtask

  task automatic test_basic();
    logic rdy, bvr; logic [7:0] b, h, v; int lat; logic [3:0] cnt;
    scan(8'h77, 4'b0111, rdy, b, h, v, lat, cnt, bvr);
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", rdy); end
    n_cmp++;
    if (b !== 8'b0111_0111) begin n_bad++; $display("FAIL basic_bits: got %b want 01110111", b); end
    n_cmp++;
    if (h !== 8'b0001_0001) begin n_bad++; $display("FAIL basic_hits: got %b want 00010001", h); end
    n_cmp++;
    if (v !== 8'hFF || bvr !== 1'b0) begin
      n_bad++; $display("FAIL basic_bit_valid: got %b/%b want 11111111/0", v, bvr);
    end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++;
    if (cnt !== 4'd2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", cnt); end
    release_report();
  endtask

  task automatic test_all_ones();
    logic rdy, bvr; logic [7:0] b, h, v; int lat; logic [3:0] cnt;
    scan(8'hFF, 4'b1111, rdy, b, h, v, lat, cnt, bvr);
    n_cmp++;
    if (h !== 8'b0001_1111) begin n_bad++; $display("FAIL ones_hits: got %b want 00011111", h); end
    n_cmp++;
    if (cnt !== 4'd5 || lat !== 9) begin
      n_bad++; $display("FAIL ones_count: got %0d lat %0d want 5 lat 9", cnt, lat);
    end
    release_report();
  endtask

  task automatic test_no_carry();
    logic rdy, bvr; logic [7:0] b, h, v; int lat; logic [3:0] cnt;
    scan(8'h00, 4'b0111, rdy, b, h, v, lat, cnt, bvr);
    n_cmp++;
    if (h !== 8'h00 || cnt !== 4'd0) begin
      n_bad++; $display("FAIL zero_word: hits %b cnt %0d want 00000000 cnt 0", h, cnt);
    end
    release_report();
    scan(8'h0F, 4'b1111, rdy, b, h, v, lat, cnt, bvr);
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", rdy); end
    n_cmp++;
    if (h !== 8'b0000_0001 || cnt !== 4'd1) begin
      n_bad++; $display("FAIL next_word: hits %b cnt %0d want 00000001 cnt 1", h, cnt);
    end
    release_report();
  endtask

  task automatic test_backpressure();
    logic rdy, bvr; logic [7:0] b, h, v; int lat; logic [3:0] cnt;
    scan(8'h77, 4'b0111, rdy, b, h, v, lat, cnt, bvr);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    pat      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_count !== 4'd2 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d: ov %b cnt %0d rdy %b want 1 2 0", i, out_valid, out_count,
                 in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bit_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: rdy/ov/bv got %b%b%b want 100", in_ready, out_valid, bit_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    int bad_cycles;
    in_valid = 1'b1; in_data = 8'hFF; pat = 4'b1111; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (hit !== 1'b1 || bit_valid !== 1'b1) begin
      n_bad++; $display("FAIL idx4_hit: hit/bv got %b%b want 11", hit, bit_valid);
    end
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, bit_out, bit_valid, hit, out_valid, out_count} !== 9'd0) begin
      n_bad++;
      $display("FAIL rst_low_outputs: got %b want 0",
               {in_ready, bit_out, bit_valid, hit, out_valid, out_count});
    end
    @(negedge clk);
    RSTn = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, bit_out, bit_valid, hit, out_valid, out_count} !== 9'd0) begin
      n_bad++;
      $display("FAIL rst_after_outputs: got %b want 0",
               {in_ready, bit_out, bit_valid, hit, out_valid, out_count});
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    bad_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || bit_valid || hit) bad_cycles++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++; $display("FAIL abandoned_word: active cycles got %0d want 0", bad_cycles);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int pulses;
    in_valid_b = 1'b1; in_data_b = 8'hFF; pat_b = 4'b1111; out_ready_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      if (hit_b) pulses++;
      if (out_valid_b) break;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 5) begin n_bad++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
    n_cmp++;
    if (out_valid_b !== 1'b1 || out_count_b !== 2'd3) begin
      n_bad++; $display("FAIL sat_count: ov %b cnt %0d want 1 3", out_valid_b, out_count_b);
    end
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_no_carry();
    test_backpressure();
    test_reset_mid_shift();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Word-level controller that sequences serial pattern detection. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first through a 4-bit pattern window, one bit per cycle. It counts matches against a pattern latched per word and returns the count over a second valid/ready handshake. It sits between a parallel data source and the team's serial pattern-detect path, replacing free-running, reset-less detection with a per-word, restartable, programmable scan.

## Interface
Parameters:
- WIDTH, 8, bits per word; legal range 4..32.
- CNT_W, 4, width of the match counter; must satisfy 2^CNT_W - 1 >= 1.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- in_valid  in  1  word available.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is shifted first.
- pat  in  4  pattern to match, oldest bit in pat[3]; sampled with in_data.
- bit_out  out  1  bit currently being scanned.
- bit_valid  out  1  high during every scan cycle.
- hit  out  1  high in the scan cycle that completes a match.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_count  out  CNT_W  number of matches in the last word.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1; bit_valid=0; out_valid=0.
  - On in_valid && in_ready: latch in_data and pat; clear window, bit index idx and count; go to SHIFT.
- SHIFT (one bit per cycle, idx = 0..WIDTH-1):
  - in_ready=0; bit_valid=1; bit_out = word[WIDTH-1-idx].
  - cand = {window[2:0], bit_out}; hit = (idx >= 3) && (cand == pat). hit is combinational in the same cycle as bit_out.
  - At the clock edge: window <= cand; if hit, count <= count+1, saturating at 2^CNT_W - 1; idx <= idx+1.
  - When idx == WIDTH-1, go to REPORT at that edge.
- Matching rules:
  - Overlapping matches are all counted.
  - The window never carries over between words; each word starts empty.
  - No hit is possible for idx 0..2.
- REPORT:
  - out_valid=1; out_count = count, held stable.
  - in_ready=0; bit_valid=0; hit=0.
  - On out_ready, return to IDLE.
- in_data and pat are ignored outside the accepting handshake cycle.
- Changes to pat during SHIFT have no effect.

## Timing
- Reset (RSTn low at an edge):
  - state=IDLE; count, window and idx cleared.
  - All outputs 0, including in_ready, while RSTn is low.
  - in_ready rises in the first cycle after RSTn is sampled high.
- Reset mid-SHIFT or mid-REPORT abandons the word. No out_valid and no further hit for that word.
- Latency: for a word accepted at edge k:
  - SHIFT occupies cycles k+1 .. k+WIDTH.
  - out_valid is first high in cycle k+WIDTH+1.
- Throughput: at most one word per WIDTH+2 cycles. A new word is accepted only in IDLE, never in the same cycle out_ready completes REPORT.
- Backpressure: while out_ready is low, out_valid and out_count hold, and in_ready stays 0 indefinitely.
- out_valid and in_ready are never high in the same cycle.
- bit_valid is high for exactly WIDTH consecutive cycles per word.
- Saturation: count stops at 2^CNT_W - 1. hit still pulses for every match.

## Test plan
- Defaults, in_data=0x77, pat=4'b0111:
  - bit_out sequence 0,1,1,1,0,1,1,1.
  - hit high at idx 3 and idx 7 only.
  - out_count=2, with out_valid first high 9 cycles after the accept edge.
- in_data=0xFF, pat=4'b1111 -> hit at idx 3..7 (5 pulses), out_count=5.
- in_data=0x00, pat=4'b0111 -> no hit, out_count=0. Next word 0x0F with pat=4'b1111 -> out_count=1, with no match carried from the prior word.
- Hold out_ready low for 5 cycles in REPORT:
  - out_valid=1 and out_count stay stable.
  - in_ready=0 throughout, and in_valid is ignored.
  - Release out_ready -> IDLE, then in_ready=1 in the next cycle.
- Assert RSTn low during SHIFT at idx 4 for one cycle:
  - All outputs 0 in the following cycle.
  - No out_valid for the abandoned word; in_ready=1 one cycle after RSTn returns high.
- CNT_W=2, in_data=0xFF, pat=4'b1111 -> 5 hit pulses, out_count=3 (saturated).
